// File: rtl/button_conditioner.sv
// Raw push-button to clean control strobes: 2-flop synchroniser, debounce,
// press/release edge pulses, and a press/hold/repeat FSM producing step and toggle.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic step_o,
  output logic toggle_o
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HC_MX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HC_W  = $clog2(HC_MX + 1);

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } state_t;

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            level_q, level_d;
  logic            press_q, release_q;
  logic            rise, fall;
  state_t          state_q;
  logic [HC_W-1:0] hcnt_q;
  logic            step_q, toggle_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synchronised input agrees with level restarts qualification.
  always_comb begin
    level_d  = level_q;
    db_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) level_d = sync2_q;
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  // A falling level pre-empts any hold or repeat step due on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= RELEASED;
      hcnt_q   <= '0;
      step_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (fall) begin
        state_q <= RELEASED;
        hcnt_q  <= '0;
      end else begin
        case (state_q)
          RELEASED: begin
            if (rise) begin
              state_q  <= PRESSED;
              hcnt_q   <= '0;
              step_q   <= 1'b1;
              toggle_q <= ~toggle_q;
            end
          end
          PRESSED: begin
            if (hcnt_q == HC_W'(HOLD_CYCLES - 1)) begin
              state_q <= REPEATING;
              hcnt_q  <= '0;
              step_q  <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          REPEATING: begin
            if (hcnt_q == HC_W'(REPEAT_CYCLES - 1)) begin
              hcnt_q <= '0;
              step_q <= 1'b1;
            end else begin
              hcnt_q <= hcnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= RELEASED;
            hcnt_q  <= '0;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign step_o    = step_q;
  assign toggle_o  = toggle_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner at DEBOUNCE=4, HOLD=16, REPEAT=8.
module tb_button_conditioner;

  logic clk;
  logic rst_n;
  logic btn;
  logic level, press, rel, step, toggle;
  logic [4:0] outs;

  int n_tot = 0;
  int n_bad = 0;
  int edge_n = 0;
  int n_press = 0;
  int n_overlap = 0;
  int step_e[$];
  int e0, p, p0;
  int seq3[11] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1, 1};
  int got;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (16),
    .REPEAT_CYCLES  (8)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .btn_i    (btn),
    .level_o  (level),
    .press_o  (press),
    .release_o(rel),
    .step_o   (step),
    .toggle_o (toggle)
  );

  assign outs = {level, press, rel, step, toggle};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_tot++;
    if (got_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  // One rising edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (step) step_e.push_back(edge_n);
    if (press) n_press++;
    if (press && rel) n_overlap++;
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;

    // reset held with a toggling button
    for (int i = 0; i < 4; i++) begin
      btn = i[0];
      tick();
      chk("rst_outs", {27'd0, outs}, 32'd0);
    end
    rst_n = 1'b1;
    btn   = 1'b0;
    repeat (5) tick();
    chk("idle_outs", {27'd0, outs}, 32'd0);

    // clean press: sampled at e0, level up after e0+5
    step_e.delete();
    btn = 1'b1;
    e0  = edge_n + 1;
    repeat (5) tick();
    chk("t2_pre_level", {31'd0, level}, 32'd0);
    tick();
    chk("t2_press_cycle", {27'd0, outs}, 32'b11011);
    tick();
    chk("t2_after_press", {27'd0, outs}, 32'b10001);
    repeat (3) tick();
    btn = 1'b0;
    repeat (5) tick();
    chk("t2_rel_pre_level", {31'd0, level}, 32'd1);
    tick();
    chk("t2_release_cycle", {27'd0, outs}, 32'b00101);
    tick();
    chk("t2_idle", {27'd0, outs}, 32'b00001);
    chk("t2_nsteps", step_e.size(), 1);
    got = (step_e.size() > 0) ? step_e[0] : -1;
    chk("t2_step_edge", got, e0 + 5);

    // bounce: sync2 settles four cycles in a row only from btn index 5
    step_e.delete();
    p0 = n_press;
    e0 = edge_n + 1;
    for (int i = 0; i < 11; i++) begin
      btn = seq3[i][0];
      tick();
      if (i == 9) chk("t3_no_early_level", {31'd0, level}, 32'd0);
    end
    chk("t3_level", {31'd0, level}, 32'd1);
    btn = 1'b1;
    repeat (3) tick();
    chk("t3_npress", n_press - p0, 1);
    chk("t3_nsteps", step_e.size(), 1);
    got = (step_e.size() > 0) ? step_e[0] : -1;
    chk("t3_step_edge", got, e0 + 10);
    chk("t3_toggle", {31'd0, toggle}, 32'd0);
    btn = 1'b0;
    repeat (8) tick();
    chk("t3_released", {31'd0, level}, 32'd0);

    // hold 50 cycles: P, P+16, then every 8
    step_e.delete();
    btn = 1'b1;
    e0  = edge_n + 1;
    p   = e0 + 5;
    repeat (50) tick();
    btn = 1'b0;
    repeat (8) tick();
    chk("t4_nsteps", step_e.size(), 6);
    for (int k = 0; k < 6; k++) begin
      got = (step_e.size() > k) ? step_e[k] : -1;
      chk($sformatf("t4_step%0d", k), got, (k == 0) ? p : p + 16 + 8 * (k - 1));
    end
    chk("t4_toggle", {31'd0, toggle}, 32'd1);

    // release race: level falls exactly when the first repeat would fire
    step_e.delete();
    btn = 1'b1;
    e0  = edge_n + 1;
    p   = e0 + 5;
    repeat (24) tick();
    btn = 1'b0;
    repeat (5) tick();
    chk("t5_level_before", {31'd0, level}, 32'd1);
    tick();
    chk("t5_race_cycle", {27'd0, outs}, 32'b00100);
    chk("t5_nsteps", step_e.size(), 2);
    got = (step_e.size() > 1) ? step_e[1] : -1;
    chk("t5_hold_step", got, p + 16);
    repeat (6) tick();
    btn = 1'b1;
    repeat (6) tick();
    chk("t5_repress", {27'd0, outs}, 32'b11011);

    // reset mid-hold, button still pressed
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear", {27'd0, outs}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_in_reset", {27'd0, outs}, 32'd0);
    end
    rst_n = 1'b1;
    step_e.delete();
    e0 = edge_n + 1;
    repeat (5) tick();
    chk("t6_pre_level", {31'd0, level}, 32'd0);
    tick();
    chk("t6_fresh_press", {27'd0, outs}, 32'b11011);
    got = (step_e.size() > 0) ? step_e[0] : -1;
    chk("t6_step_edge", got, e0 + 5);
    btn = 1'b0;
    repeat (8) tick();

    chk("press_release_excl", n_overlap, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
